// File: rtl/regfile_scoreboard.sv
// Integer register file with x0 hardwired to zero, write-to-read bypass,
// and per-register busy bits that gate issue on RAW/WAW hazards.
module regfile_scoreboard #(
    parameter  int XLEN = 64,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_ena,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            kill_ena,
    input  logic [AW-1:0]   kill_addr,
    input  logic            rs1_ena,
    input  logic [AW-1:0]   rs1_addr,
    input  logic            rs2_ena,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_valid,
    input  logic            issue_rd_ena,
    input  logic [AW-1:0]   issue_rd,
    output logic            stall,
    output logic [NREG-1:0] busy_vec
);

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] rf     [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            accept;

    always_comb begin
        rf[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            rf[i] = regs_q[i];
        end
    end

    function automatic logic [XLEN-1:0] rd_port(
        input logic          ena,
        input logic [AW-1:0] addr
    );
        if (!ena || addr == '0) begin
            return '0;
        end else if (wb_ena && wb_addr == addr) begin
            return wb_data;
        end else begin
            return rf[addr];
        end
    endfunction

    // A producer releasing its register this cycle no longer blocks issue.
    function automatic logic hazard(input logic [AW-1:0] r);
        return (r != '0) && busy_q[r]
            && !(wb_ena && wb_addr == r)
            && !(kill_ena && kill_addr == r);
    endfunction

    assign rs1_data = rd_port(rs1_ena, rs1_addr);
    assign rs2_data = rd_port(rs2_ena, rs2_addr);

    assign stall = issue_valid && (
        (rs1_ena && hazard(rs1_addr)) ||
        (rs2_ena && hazard(rs2_addr)) ||
        (issue_rd_ena && hazard(issue_rd)));

    assign accept   = issue_valid && !stall;
    assign busy_vec = busy_q;

    // Later assignments win: a new producer overrides a same-cycle release.
    always_comb begin
        busy_d = busy_q;
        if (wb_ena) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (kill_ena) begin
            busy_d[kill_addr] = 1'b0;
        end
        if (accept && issue_rd_ena && issue_rd != '0) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_ena) begin
            for (int i = 1; i < NREG; i++) begin
                if (wb_addr == AW'(i)) begin
                    regs_q[i] <= wb_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: per-cycle expectations from an
// array-based model are queued and checked by a separate negedge monitor.
module tb_regfile_scoreboard;

    localparam int XLEN = 64;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wb_ena = 1'b0;
    logic [4:0]      wb_addr = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic            kill_ena = 1'b0;
    logic [4:0]      kill_addr = '0;
    logic            rs1_ena = 1'b0;
    logic [4:0]      rs1_addr = '0;
    logic            rs2_ena = 1'b0;
    logic [4:0]      rs2_addr = '0;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            issue_valid = 1'b0;
    logic            issue_rd_ena = 1'b0;
    logic [4:0]      issue_rd = '0;
    logic            stall;
    logic [NREG-1:0] busy_vec;

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .wb_ena(wb_ena), .wb_addr(wb_addr), .wb_data(wb_data),
        .kill_ena(kill_ena), .kill_addr(kill_addr),
        .rs1_ena(rs1_ena), .rs1_addr(rs1_addr),
        .rs2_ena(rs2_ena), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .issue_rd_ena(issue_rd_ena),
        .issue_rd(issue_rd), .stall(stall), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           tag;
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        logic            st;
        logic [NREG-1:0] bv;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: architectural values and outstanding producers.
    logic [XLEN-1:0] m_val [NREG];
    bit              m_busy [NREG];

    function automatic logic [XLEN-1:0] m_read(bit ena, int a);
        if (!ena || a == 0) return '0;
        if (wb_ena && int'(wb_addr) == a) return wb_data;
        return m_val[a];
    endfunction

    function automatic bit m_blocked(int r);
        if (r == 0 || !m_busy[r]) return 0;
        if (wb_ena && int'(wb_addr) == r) return 0;
        if (kill_ena && int'(kill_addr) == r) return 0;
        return 1;
    endfunction

    function automatic bit m_stall();
        bit h;
        h = (rs1_ena && m_blocked(int'(rs1_addr)))
         || (rs2_ena && m_blocked(int'(rs2_addr)))
         || (issue_rd_ena && m_blocked(int'(issue_rd)));
        return issue_valid && h;
    endfunction

    task automatic idle();
        wb_ena = 0; kill_ena = 0; rs1_ena = 0; rs2_ena = 0;
        issue_valid = 0; issue_rd_ena = 0;
        wb_addr = 0; kill_addr = 0; rs1_addr = 0; rs2_addr = 0;
        issue_rd = 0; wb_data = '0;
    endtask

    task automatic tick(string tag, bit check = 1);
        exp_t e;
        bit   st;
        st = m_stall();
        if (check) begin
            e.tag = tag;
            e.r1  = m_read(rs1_ena, int'(rs1_addr));
            e.r2  = m_read(rs2_ena, int'(rs2_addr));
            e.st  = st;
            for (int i = 0; i < NREG; i++) e.bv[i] = m_busy[i];
            exp_q.push_back(e);
        end
        @(negedge clk);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_val[i] = '0;
                m_busy[i] = 0;
            end
        end else begin
            if (wb_ena && wb_addr != 0) m_val[wb_addr] = wb_data;
            if (wb_ena) m_busy[wb_addr] = 0;
            if (kill_ena) m_busy[kill_addr] = 0;
            if (issue_valid && !st && issue_rd_ena && issue_rd != 0)
                m_busy[issue_rd] = 1;
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (rs1_data !== e.r1) begin
                    miscompares++;
                    $display("FAIL %s rs1_data got %h want %h", e.tag, rs1_data, e.r1);
                end
                if (rs2_data !== e.r2) begin
                    miscompares++;
                    $display("FAIL %s rs2_data got %h want %h", e.tag, rs2_data, e.r2);
                end
                if (stall !== e.st) begin
                    miscompares++;
                    $display("FAIL %s stall got %b want %b", e.tag, stall, e.st);
                end
                if (busy_vec !== e.bv) begin
                    miscompares++;
                    $display("FAIL %s busy_vec got %h want %h", e.tag, busy_vec, e.bv);
                end
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < NREG; i++) begin
            m_val[i] = '0;
            m_busy[i] = 0;
        end
        idle();
        rst = 1;
        tick("rst0", 0);
        tick("rst1");
        rst = 0;
        rs1_ena = 1; rs1_addr = 5; rs2_ena = 1; rs2_addr = 31;
        tick("post_rst_read");

        idle();
        wb_ena = 1; wb_addr = 5; wb_data = 64'hDEAD_BEEF_0000_0001;
        rs1_ena = 1; rs1_addr = 5;
        tick("bypass");
        wb_ena = 0;
        tick("storage_read");
        idle();
        wb_ena = 1; wb_addr = 0; wb_data = 64'h1234;
        tick("x0_write");
        idle();
        rs1_ena = 1; rs1_addr = 0; rs2_ena = 1; rs2_addr = 0;
        tick("x0_read");

        idle();
        issue_valid = 1; issue_rd_ena = 1; issue_rd = 7;
        tick("issue_rd7");
        idle();
        issue_valid = 1; rs1_ena = 1; rs1_addr = 7;
        tick("raw_stall");
        wb_ena = 1; wb_addr = 7; wb_data = 64'h42;
        tick("raw_release");
        idle();
        rs1_ena = 1; rs1_addr = 7;
        tick("after_release");

        idle();
        issue_valid = 1; issue_rd_ena = 1; issue_rd = 3;
        tick("issue_rd3");
        tick("waw_stall");
        kill_ena = 1; kill_addr = 3;
        tick("waw_kill");
        idle();
        rs1_ena = 1; rs1_addr = 3;
        tick("x3_after_kill");
        idle();
        kill_ena = 1; kill_addr = 3;
        tick("kill3_cleanup");

        idle();
        wb_ena = 1; wb_addr = 10; wb_data = 64'h1010_1010_1010_1010;
        tick("seed_x10");
        idle();
        issue_valid = 1; issue_rd_ena = 1; issue_rd = 9;
        tick("issue_rd9");
        issue_rd = 10;
        tick("issue_rd10");
        idle();
        wb_ena = 1; wb_addr = 9; wb_data = 64'h0909_0000_ABCD_0009;
        kill_ena = 1; kill_addr = 10;
        issue_valid = 1; issue_rd_ena = 1; issue_rd = 11;
        rs2_ena = 1; rs2_addr = 9;
        tick("simultaneous");
        idle();
        rs1_ena = 1; rs1_addr = 10; rs2_ena = 1; rs2_addr = 9;
        tick("after_simul");

        idle();
        issue_valid = 1; issue_rd_ena = 1;
        issue_rd = 1; tick("issue_rd1");
        issue_rd = 2; tick("issue_rd2");
        issue_rd = 3; tick("issue_rd3b");
        idle();
        rst = 1;
        wb_ena = 1; wb_addr = 1; wb_data = 64'hFFFF;
        tick("mid_rst");
        rst = 0;
        idle();
        issue_valid = 1; issue_rd_ena = 1; issue_rd = 4;
        rs1_ena = 1; rs1_addr = 1;
        tick("post_mid_rst");

        for (int n = 0; n < 400; n++) begin
            idle();
            rst          = ($urandom_range(0, 99) == 0);
            wb_ena       = $urandom_range(0, 2) == 0;
            wb_addr      = 5'($urandom_range(0, 7));
            wb_data      = {$urandom, $urandom};
            kill_ena     = $urandom_range(0, 5) == 0;
            kill_addr    = 5'($urandom_range(0, 7));
            rs1_ena      = $urandom_range(0, 1) == 1;
            rs1_addr     = 5'($urandom_range(0, 7));
            rs2_ena      = $urandom_range(0, 1) == 1;
            rs2_addr     = 5'($urandom_range(0, 7));
            issue_valid  = $urandom_range(0, 1) == 1;
            issue_rd_ena = $urandom_range(0, 3) != 0;
            issue_rd     = 5'($urandom_range(0, 7));
            tick("random");
        end
        rst = 0;
        idle();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Architectural integer register file with an integrated pending-write scoreboard; it is the consumer of the writeback stage's `wb_data`/`wb_ena`/`wb_addr` bundle. It provides two combinational read ports to decode, with write-to-read bypass, and holds x0 at zero. Per-register busy bits are set when decode issues an instruction with a destination, and are cleared at writeback or on squash. The block raises `stall` on RAW or WAW hazards against in-flight producers.

## Interface
- XLEN, 64, data width (matches REG_BUS)
- NREG, 32, register count; address width 5
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- wb_ena  input  1  writeback write enable
- wb_addr  input  5  writeback destination
- wb_data  input  XLEN  writeback data
- kill_ena  input  1  squashed in-flight instruction releases its destination without writing
- kill_addr  input  5  destination being released
- rs1_ena, rs2_ena  input  1 each  source operand used
- rs1_addr, rs2_addr  input  5 each  source indices
- rs1_data, rs2_data  output  XLEN each  operand data, combinational
- issue_valid  input  1  decode presents an instruction this cycle
- issue_rd_ena  input  1  instruction writes a destination
- issue_rd  input  5  destination index
- stall  output  1  issue blocked this cycle, combinational
- busy_vec  output  NREG  current busy bits, for debug/perf; bit 0 always 0

## Operation
- Storage: regs[1..NREG-1] of XLEN bits. Index 0 is not stored; reads of x0 return 0, and writes to x0 are dropped.
- Write: at posedge, if wb_ena and wb_addr!=0, then regs[wb_addr] <= wb_data.
- Read port n: rsn_data = 0 if !rsn_ena or rsn_addr==0. Otherwise it is wb_data if wb_ena and wb_addr==rsn_addr (bypass). Otherwise it is regs[rsn_addr].
- Hazard(r) = (r!=0) & busy[r] & !(wb_ena & wb_addr==r) & !(kill_ena & kill_addr==r). A register whose release happens this cycle is not a hazard.
- stall = issue_valid & ((rs1_ena & Hazard(rs1_addr)) | (rs2_ena & Hazard(rs2_addr)) | (issue_rd_ena & Hazard(issue_rd))). The last term is the WAW block, so each register has at most one outstanding producer.
- accept = issue_valid & !stall.
- Busy update at posedge, applied in priority order, low to high:
  - clear busy[wb_addr] if wb_ena;
  - clear busy[kill_addr] if kill_ena;
  - set busy[issue_rd] if accept & issue_rd_ena & issue_rd!=0.
- Set wins over clear on the same index in the same cycle, because the new producer is the later instruction.
- busy[0] is never set.
- wb_ena or kill_ena against a non-busy register is legal. The write still occurs and the busy bit stays 0.
- wb_ena and kill_ena on the same index in the same cycle is illegal upstream. Behaviour: the write occurs and the busy bit clears.

## Timing
- Reset: at posedge with rst=1, all regs <= 0 and busy_vec <= 0.
  - During rst, writes and issue sets are suppressed.
  - stall and rsn_data still evaluate combinationally against the current state.
- After reset, all outputs read 0: busy_vec=0, stall=0, rs1_data=rs2_data=0.
- Reset mid-operation discards all pending busy bits. Upstream flushes the pipeline together with reset.
- Read latency is 0 cycles: combinational from the addresses, and from the wb bundle via the bypass.
- A write becomes visible from storage at the cycle after the edge, and in the same cycle via the bypass.
- Issue-to-busy latency is 1 edge. stall responds in the same cycle to wb/kill releases.
- No internal pipelining and no multi-cycle paths.

## Test plan
- **Reset then read.** Assert rst for 2 cycles, then read x5/x31 with ena=1.
  - Expect rs1_data=rs2_data=0, busy_vec=0 and stall=0.
- **Write, read, bypass.**
  - wb_ena=1, wb_addr=5, wb_data=0xDEAD_BEEF_0000_0001. In the same cycle rs1_addr=5 → rs1_data equals that value (bypass).
  - Next cycle, with wb_ena=0 → rs1_data is still that value, read from storage.
  - wb_addr=0 with data 0x1234 → a later read of x0 returns 0.
- **RAW stall and release.**
  - Issue rd=7 (accepted). The next cycle, issue with rs1=7 → stall=1 while busy_vec[7]=1.
  - In the cycle wb_ena=1, wb_addr=7, wb_data=0x42: stall=0, rs1_data=0x42, and busy_vec[7] is 0 after the edge.
- **WAW block.**
  - With busy[3] set, issue rd=3 and no sources → stall=1.
  - Assert kill_ena, kill_addr=3 in the same cycle → stall=0. After the edge busy_vec[3]=1 (set wins) and regs[3] is unchanged.
- **Simultaneous events.**
  - In one cycle: wb to x9, kill of x10, accepted issue to x11, and rs2 reads x9.
  - Expect rs2_data=wb_data. After the edge busy[9]=busy[10]=0, busy[11]=1, and regs[10] is unchanged.
- **Reset mid-flight.**
  - Set busy on x1, x2, x3, then assert rst for 1 cycle together with wb_ena=1, wb_addr=1.
  - Expect busy_vec=0 and regs[1]=0 afterwards. An issue reading x1 is not stalled.
